// File: rtl/run_det_pkg.sv
// Shared types and constants for the run-length detector.
package run_det_pkg;

    // Run-history state: no history, or a run of 0s / 1s in progress.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN0 = 2'd1,
        RUN1 = 2'd2
    } state_t;

    // Detection enables; bit index equals the symbol being enabled.
    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_ZERO = 2'b01;
    localparam logic [1:0] MODE_ONE  = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

endpackage

// File: rtl/run_detector_sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one.
module sat_counter #(
    parameter int unsigned     WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX  = '1
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Priority: clear, then load-to-1, then saturating increment.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= WIDTH'(1);
        end else if (inc && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/run_detector.sv
// Mealy run-length detector: flags bits that extend a run of identical
// symbols to RUN_LEN or more, with per-symbol enables, a one-shot pulse
// and a saturating detection counter.
module run_detector
    import run_det_pkg::*;
#(
    parameter int unsigned RUN_LEN = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned LEN_W   = $clog2(RUN_LEN + 1)
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in,
    input  logic [1:0]       mode,
    output logic             out,
    output logic             det,
    output logic             out_sym,
    output logic [LEN_W-1:0] run_len,
    output logic [CNT_W-1:0] det_cnt
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(RUN_LEN);

    state_t           state;
    state_t           state_nxt;
    logic             qual;
    logic             match;
    logic             en;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] n;

    assign cnt     = run_len;
    assign out_sym = (state == RUN1);

    // Next-state and Mealy outputs from current state and the incoming bit.
    always_comb begin
        qual  = in_valid & ~clear;
        match = ((state == RUN1) && in) || ((state == RUN0) && !in);
        en    = mode[in];
        if (match) begin
            n = (cnt == LEN_MAX) ? LEN_MAX : cnt + 1'b1;
        end else begin
            n = LEN_W'(1);
        end

        out = qual & en & (n >= LEN_MAX);
        det = qual & en & (n == LEN_MAX) & ((cnt < LEN_MAX) | (state == IDLE));

        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else if (in_valid) begin
            state_nxt = in ? RUN1 : RUN0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Run length: restart at 1 on a new symbol, else extend up to RUN_LEN.
    sat_counter #(
        .WIDTH (LEN_W),
        .MAX   (LEN_MAX)
    ) u_len (
        .clk   (clk),
        .RESET (RESET),
        .clr   (clear),
        .load  (qual & ~match),
        .inc   (qual & match),
        .count (run_len)
    );

    // Detection-event counter, holds at all-ones.
    sat_counter #(
        .WIDTH (CNT_W),
        .MAX   ({CNT_W{1'b1}})
    ) u_det (
        .clk   (clk),
        .RESET (RESET),
        .clr   (clear),
        .load  (1'b0),
        .inc   (det),
        .count (det_cnt)
    );

endmodule

// File: tb/tb_run_detector.sv
// Directed vector bench for run_detector (RUN_LEN=4, CNT_W=8).
module tb_run_detector;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_b = 1'b0;
    logic [1:0] mode = 2'b11;
    logic       out;
    logic       det;
    logic       out_sym;
    logic [2:0] run_len;
    logic [7:0] det_cnt;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       clr;
        logic       vld;
        logic       b;
        logic [1:0] md;
        logic       o;
        logic       d;
        int         rl;
        logic       sym;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    run_detector #(
        .RUN_LEN (4),
        .CNT_W   (8)
    ) dut (
        .clk      (clk),
        .RESET    (RESET),
        .clear    (clear),
        .in_valid (in_valid),
        .in       (in_b),
        .mode     (mode),
        .out      (out),
        .det      (det),
        .out_sym  (out_sym),
        .run_len  (run_len),
        .det_cnt  (det_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic clr, input logic vld, input logic b,
                                input logic [1:0] md, input logic o, input logic d,
                                input int rl, input logic sym, input int cnt);
        vec_t v;
        v.clr = clr; v.vld = vld; v.b = b; v.md = md;
        v.o = o; v.d = d; v.rl = rl; v.sym = sym; v.cnt = cnt;
        return v;
    endfunction

    task automatic drive(input logic clr, input logic vld, input logic b, input logic [1:0] md);
        @(negedge clk);
        clear = clr; in_valid = vld; in_b = b; mode = md;
        #1;
    endtask

    task automatic apply(input vec_t v, input string tag);
        drive(v.clr, v.vld, v.b, v.md);
        chk({tag, ".out"}, int'(out), int'(v.o));
        chk({tag, ".det"}, int'(det), int'(v.d));
        @(posedge clk);
        #1;
        chk({tag, ".run_len"}, int'(run_len), v.rl);
        chk({tag, ".out_sym"}, int'(out_sym), int'(v.sym));
        chk({tag, ".det_cnt"}, int'(det_cnt), v.cnt);
    endtask

    initial begin
        // clr vld b md   out det rl sym cnt
        vecs.push_back(mk(1, 0, 0, 2'b11, 0, 0, 0, 0, 0));
        // mode 11: 0,0,0,0,0,1
        vecs.push_back(mk(0, 1, 0, 2'b11, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'b11, 0, 0, 2, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'b11, 0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'b11, 1, 1, 4, 0, 1));
        vecs.push_back(mk(0, 1, 0, 2'b11, 1, 0, 4, 0, 1));
        vecs.push_back(mk(0, 1, 1, 2'b11, 0, 0, 1, 1, 1));
        // mode 01: ones never flagged, length still tracked
        vecs.push_back(mk(1, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 2'b01, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 2'b01, 0, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, 1, 2'b01, 0, 0, 3, 1, 0));
        vecs.push_back(mk(0, 1, 1, 2'b01, 0, 0, 4, 1, 0));
        vecs.push_back(mk(0, 1, 1, 2'b01, 0, 0, 4, 1, 0));
        // enabling ones on a saturated run: out but no det
        vecs.push_back(mk(0, 1, 1, 2'b10, 1, 0, 4, 1, 0));
        vecs.push_back(mk(0, 0, 1, 2'b11, 0, 0, 4, 1, 0));
        // 0,0, gap of 3, 0,0
        vecs.push_back(mk(1, 0, 0, 2'b11, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'b11, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'b11, 0, 0, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b11, 0, 0, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b11, 0, 0, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b11, 0, 0, 2, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'b11, 0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'b11, 1, 1, 4, 0, 1));
        vecs.push_back(mk(0, 1, 0, 2'b00, 0, 0, 4, 0, 1));
        vecs.push_back(mk(0, 1, 0, 2'b01, 1, 0, 4, 0, 1));
        // clear wins over in_valid
        vecs.push_back(mk(1, 1, 0, 2'b11, 0, 0, 0, 0, 0));
        // mid-run clear after three ones, then restart
        vecs.push_back(mk(0, 1, 1, 2'b11, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 2'b11, 0, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, 1, 2'b11, 0, 0, 3, 1, 0));
        vecs.push_back(mk(1, 1, 1, 2'b11, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 2'b11, 0, 0, 1, 1, 0));
        // mode 10: run of zeros not flagged
        vecs.push_back(mk(0, 1, 0, 2'b10, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'b10, 0, 0, 2, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'b10, 0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'b10, 0, 0, 4, 0, 0));

        // Reset state while RESET is held.
        #2;
        chk("reset.out", int'(out), 0);
        chk("reset.det", int'(det), 0);
        chk("reset.run_len", int'(run_len), 0);
        chk("reset.out_sym", int'(out_sym), 0);
        chk("reset.det_cnt", int'(det_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        RESET = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Counter saturation: 255 alternating runs of four.
        drive(1, 0, 0, 2'b11);
        for (int k = 0; k < 255; k++) begin
            for (int j = 0; j < 4; j++) begin
                drive(0, 1, logic'(k % 2), 2'b11);
            end
        end
        @(posedge clk);
        #1;
        chk("sat.det_cnt_255", int'(det_cnt), 255);
        for (int j = 0; j < 3; j++) begin
            drive(0, 1, 1, 2'b11);
        end
        drive(0, 1, 1, 2'b11);
        chk("sat.det_pulse", int'(det), 1);
        chk("sat.out", int'(out), 1);
        @(posedge clk);
        #1;
        chk("sat.det_cnt_hold", int'(det_cnt), 255);

        // Asynchronous reset mid-run.
        drive(0, 1, 0, 2'b11);
        drive(0, 1, 0, 2'b11);
        @(posedge clk);
        #2;
        RESET = 1'b1;
        #1;
        chk("arst.run_len", int'(run_len), 0);
        chk("arst.out_sym", int'(out_sym), 0);
        chk("arst.det_cnt", int'(det_cnt), 0);
        chk("arst.out", int'(out), 0);
        chk("arst.det", int'(det), 0);
        @(negedge clk);
        RESET = 1'b0;
        apply(mk(0, 1, 1, 2'b11, 0, 0, 1, 1, 0), "arst.first");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/run_detector.md
# run_detector

Parametrised Mealy run-length detector for a serial bit stream. Flags every input bit that extends a run of identical symbols to RUN_LEN or more. Adds selectable symbol polarity, a valid qualifier, a one-shot detect pulse, the current run length, and a saturating detection-event counter. Sits behind the serial input stage and feeds the status/interrupt logic.

## Interface
- RUN_LEN, 4: run length that triggers detection. Legal range is ≥2.
- CNT_W, 8: width of the `det_cnt` counter.
- LEN_W, $clog2(RUN_LEN+1): width of `run_len`. Derived; do not override.
- clk  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of history and counter. Has priority over `in_valid`.
- in_valid  in  1  qualifies `in`. When low, state is held.
- in  in  1  serial data bit.
- mode  in  2  detection enables:
  - 00: off.
  - 01: runs of 0s only.
  - 10: runs of 1s only.
  - 11: runs of both symbols.
- out  out  1  Mealy level output. High when the current qualified bit makes the run length ≥RUN_LEN and that symbol is enabled.
- det  out  1  Mealy pulse. High only when the current qualified bit makes the run length exactly RUN_LEN.
- out_sym  out  1  symbol of the current run. Registered.
- run_len  out  LEN_W  length of the current run, saturating at RUN_LEN. Registered.
- det_cnt  out  CNT_W  count of `det` events, saturating at all-ones. Registered.

## Operation
- State register holds three fields:
  - FSM state: IDLE, RUN0, RUN1.
  - cnt: run length, 1..RUN_LEN.
  - det_cnt.
- IDLE means no history. It is entered on reset or `clear`.
- Qualified bit b (in_valid=1, clear=0):
  - From IDLE: go to RUN<b> with cnt=1.
  - From RUN<x>, b==x: cnt = min(cnt+1, RUN_LEN).
  - From RUN<x>, b!=x: go to RUN<b> with cnt=1.
- Next length n is the new cnt as computed above. Outputs are combinational from state, `in`, `in_valid` and `mode`:
  - en = mode[b].
  - out = in_valid & !clear & en & (n ≥ RUN_LEN).
  - det = in_valid & !clear & en & (n == RUN_LEN) & (cnt < RUN_LEN or in IDLE).
- Further identical bits keep `out` high, with no new `det`.
- `det_cnt` increments on each `det`. It holds at 2^CNT_W−1.
- `mode` only gates the outputs. Run history is tracked for both symbols regardless of mode. Changing mode mid-run does not reset the history. Enabling a symbol while a saturated run is in progress gives `out`=1 on the next matching bit but no `det`.
- in_valid=0: state and counters hold; out=det=0. A gap in valid does not break a run.
- clear=1: next state is IDLE, cnt=0, det_cnt=0; out=det=0 this cycle, irrespective of `in_valid`.
- RUN_LEN=4, mode=11 reproduces the legacy 4-zeros/4-ones detector exactly.

## Timing
- Reset values: FSM state IDLE, run_len=0, out_sym=0, det_cnt=0, out=0, det=0.
- `out` and `det` have zero latency: they are valid in the same cycle as `in`. Consumers register them.
- `run_len`, `out_sym` and `det_cnt` reflect the bit from the previous edge: 1-cycle latency.
- When RESET is asserted mid-run, all registers go to reset values immediately. The combinational outputs follow the IDLE state.
- Simultaneous `det` and counter saturation: the counter holds and `det` still pulses.
- One qualified bit per cycle. There is no backpressure.

## Structure
- Shared package `run_det_pkg`:
  - State enum (IDLE, RUN0, RUN1).
  - Mode constants: MODE_OFF, MODE_ZERO, MODE_ONE, MODE_BOTH.
- One sub-module, `sat_counter` (params WIDTH, MAX; inputs clr, inc). It is instantiated twice:
  - Run length, with MAX=RUN_LEN and a load-to-1 input.
  - `det_cnt`, with MAX=2^CNT_W−1.
- Top level contains the next-state/Mealy output logic and the state register only.

## Test plan
- RUN_LEN=4, mode=11, stream 0,0,0,0,0,1 → out=0,0,0,1,1,0; det=0,0,0,1,0,0; det_cnt=1 after the last edge.
- mode=01, stream 1,1,1,1,1 → out=det=0 throughout; run_len saturates at 4; out_sym=1.
- Stream 0,0, then in_valid=0 for 3 cycles, then 0,0 → out=1 on the 4th valid zero; out=det=0 during the gap.
- det_cnt at 255 (CNT_W=8) plus one more detection → det=1, det_cnt stays 255.
- Mid-run clear (after 3 ones), then 1 → run restarts: run_len=1, out=0, det_cnt=0.
- RESET asserted asynchronously mid-run → all registered outputs 0 before the next clk edge; first bit afterwards gives run_len=1.
